// File: rtl/spi_tx_serializer.sv
// SPI mode-0 transmit serializer for the LCD path: pops {D/C, payload} words and shifts them out MSB first.
// Optional macro SPI_TX_LSB_FIRST_EN adds a per-word lsb_first input selecting LSB-first shifting.
module spi_tx_serializer #(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 1,
    parameter int CS_HOLD = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fifo_valid,
    input  logic [DATA_W:0]   fifo_data,
    output logic              fifo_read_ready,
    input  logic              burst_en,
`ifdef SPI_TX_LSB_FIRST_EN
    input  logic              lsb_first,
`endif
    output logic              busy,
    output logic              word_done,
    output logic              CS,
    output logic              SCLK,
    output logic              D_C,
    output logic              SDA
);

    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W  = $clog2(DATA_W);
    localparam int HOLD_W = (CS_HOLD > 1) ? $clog2(CS_HOLD) : 1;

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0]  BIT_FIRST = BIT_W'(DATA_W - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(CS_HOLD - 1);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] SHIFT_LO = 2'd1;
    localparam logic [1:0] SHIFT_HI = 2'd2;
    localparam logic [1:0] HOLD     = 2'd3;

    logic [1:0]        state;
    logic [DIV_W-1:0]  div_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [DATA_W-1:0] shreg;
    logic              lsb_q;
    logic              pop_lsb;
    logic              tick;
    logic              last_bit;
    logic              pop;

`ifdef SPI_TX_LSB_FIRST_EN
    assign pop_lsb = lsb_first;
`else
    assign pop_lsb = 1'b0;
`endif

    assign tick     = (div_cnt == DIV_LAST);
    assign last_bit = (bit_cnt == '0);
    assign busy     = (state != IDLE);

    // Mid-stream pop is offered only on the final falling edge of a burst word.
    assign fifo_read_ready = (state == IDLE) ||
                             ((state == SHIFT_HI) && tick && last_bit && burst_en);
    assign pop = fifo_valid && fifo_read_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            hold_cnt  <= '0;
            shreg     <= '0;
            lsb_q     <= 1'b0;
            CS        <= 1'b1;
            SCLK      <= 1'b0;
            D_C       <= 1'b0;
            SDA       <= 1'b0;
            word_done <= 1'b0;
        end else begin
            word_done <= 1'b0;
            case (state)
                IDLE: begin
                    SCLK <= 1'b0;
                    if (pop) begin
                        shreg   <= fifo_data[DATA_W-1:0];
                        D_C     <= fifo_data[DATA_W];
                        SDA     <= pop_lsb ? fifo_data[0] : fifo_data[DATA_W-1];
                        lsb_q   <= pop_lsb;
                        CS      <= 1'b0;
                        bit_cnt <= BIT_FIRST;
                        div_cnt <= '0;
                        state   <= SHIFT_LO;
                    end
                end
                SHIFT_LO: begin
                    if (tick) begin
                        SCLK    <= 1'b1;
                        div_cnt <= '0;
                        state   <= SHIFT_HI;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                SHIFT_HI: begin
                    if (tick) begin
                        SCLK    <= 1'b0;
                        div_cnt <= '0;
                        if (!last_bit) begin
                            bit_cnt <= bit_cnt - 1'b1;
                            if (lsb_q) begin
                                shreg <= shreg >> 1;
                                SDA   <= shreg[1];
                            end else begin
                                shreg <= shreg << 1;
                                SDA   <= shreg[DATA_W-2];
                            end
                            state <= SHIFT_LO;
                        end else begin
                            word_done <= 1'b1;
                            // Burst chaining: next word loads on this same edge with CS kept low.
                            if (pop) begin
                                shreg   <= fifo_data[DATA_W-1:0];
                                D_C     <= fifo_data[DATA_W];
                                SDA     <= pop_lsb ? fifo_data[0] : fifo_data[DATA_W-1];
                                lsb_q   <= pop_lsb;
                                bit_cnt <= BIT_FIRST;
                                state   <= SHIFT_LO;
                            end else begin
                                hold_cnt <= '0;
                                state    <= HOLD;
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        CS    <= 1'b1;
                        state <= IDLE;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_tx_serializer.sv
// Scoreboard bench for spi_tx_serializer: two instances (fast and divided SCLK) driven with directed and
// random words; a per-cycle monitor rebuilds each word from the pins and checks it and its timing.
module tb_spi_tx_serializer;

    localparam int DW = 8;
    localparam int C0 = 1, H0 = 1;
    localparam int C1 = 4, H1 = 3;
`ifdef SPI_TX_LSB_FIRST_EN
    localparam bit LSB_EN = 1'b1;
`else
    localparam bit LSB_EN = 1'b0;
`endif

    logic clk, rst_n;
    logic        fifo_valid [2];
    logic [DW:0] fifo_data  [2];
    logic        burst_en   [2];
    logic        lsb_first  [2];
    logic        ready [2], busy [2], wd [2], cs [2], sclk [2], dc [2], sda [2];

    int n_chk = 0, n_fail = 0, cyc = 0;
    logic [DW:0] exp_q [2][$];

    spi_tx_serializer #(.DATA_W(DW), .CLK_DIV(C0), .CS_HOLD(H0)) u0 (
        .clk(clk), .rst_n(rst_n), .fifo_valid(fifo_valid[0]), .fifo_data(fifo_data[0]),
        .fifo_read_ready(ready[0]), .burst_en(burst_en[0]),
`ifdef SPI_TX_LSB_FIRST_EN
        .lsb_first(lsb_first[0]),
`endif
        .busy(busy[0]), .word_done(wd[0]), .CS(cs[0]), .SCLK(sclk[0]), .D_C(dc[0]), .SDA(sda[0]));

    spi_tx_serializer #(.DATA_W(DW), .CLK_DIV(C1), .CS_HOLD(H1)) u1 (
        .clk(clk), .rst_n(rst_n), .fifo_valid(fifo_valid[1]), .fifo_data(fifo_data[1]),
        .fifo_read_ready(ready[1]), .burst_en(burst_en[1]),
`ifdef SPI_TX_LSB_FIRST_EN
        .lsb_first(lsb_first[1]),
`endif
        .busy(busy[1]), .word_done(wd[1]), .CS(cs[1]), .SCLK(sclk[1]), .D_C(dc[1]), .SDA(sda[1]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int cdiv(input int i); return (i == 0) ? C0 : C1; endfunction
    function automatic int chold(input int i); return (i == 0) ? H0 : H1; endfunction

    // Expected word in wire order: {D/C, bits in the order they appear on SDA}.
    function automatic logic [DW:0] wire_order(input logic [DW:0] d, input logic lf);
        logic [DW:0] r;
        r[DW] = d[DW];
        for (int b = 0; b < DW; b++) r[b] = (lf && LSB_EN) ? d[DW-1-b] : d[b];
        return r;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor state, one slot per instance.
    int          cs_fall [2], rise_c [2], nbits [2], wds [2];
    bit          first [2];
    logic        p_cs [2], p_sclk [2], hs [2], hd [2], dcc [2];
    logic [DW-1:0] cap [2];

    task automatic mon(input int i);
        logic [DW:0] e;
        if (!rst_n) begin
            p_cs[i] = 1'b1; p_sclk[i] = 1'b0; nbits[i] = 0; wds[i] = 0; first[i] = 1'b0;
            return;
        end
        chk($sformatf("busy_vs_cs%0d", i), busy[i], !cs[i]);
        if (!cs[i] && p_cs[i]) begin
            cs_fall[i] = cyc; first[i] = 1'b1; wds[i] = 0;
        end
        if (sclk[i] && !p_sclk[i]) begin
            chk($sformatf("cs_at_rise%0d", i), cs[i], 0);
            if (first[i]) chk($sformatf("latency%0d", i), cyc - cs_fall[i], cdiv(i));
            else          chk($sformatf("period%0d", i), cyc - rise_c[i], 2 * cdiv(i));
            first[i] = 1'b0;
            rise_c[i] = cyc;
            cap[i] = {cap[i][DW-2:0], sda[i]};
            dcc[i] = dc[i];
            hs[i] = sda[i]; hd[i] = dc[i];
            nbits[i]++;
        end else if (sclk[i]) begin
            chk($sformatf("sda_stable%0d", i), {sda[i], dc[i]}, {hs[i], hd[i]});
        end
        if (!sclk[i] && p_sclk[i]) chk($sformatf("sclk_high%0d", i), cyc - rise_c[i], cdiv(i));
        if (wd[i]) begin
            chk($sformatf("bits_per_word%0d", i), nbits[i], DW);
            if (exp_q[i].size() == 0) begin
                chk($sformatf("unexpected_word%0d", i), {dcc[i], cap[i]}, -1);
            end else begin
                e = exp_q[i].pop_front();
                chk($sformatf("word%0d", i), {dcc[i], cap[i]}, e);
            end
            nbits[i] = 0;
            wds[i]++;
        end
        if (cs[i] && !p_cs[i])
            chk($sformatf("cs_low_len%0d", i), cyc - cs_fall[i], 2 * cdiv(i) * DW * wds[i] + chold(i));
        p_cs[i] = cs[i];
        p_sclk[i] = sclk[i];
    endtask

    always @(negedge clk) begin
        cyc++;
        mon(0);
        mon(1);
    end

    task automatic send(input int i, input logic [DW:0] d, input logic be, input logic lf);
        int t = 0;
        fifo_valid[i] = 1'b1; fifo_data[i] = d; burst_en[i] = be; lsb_first[i] = lf;
        #1;
        while (!ready[i]) begin
            @(negedge clk); #1;
            if (++t > 3000) begin
                chk($sformatf("pop_timeout%0d", i), 0, 1);
                return;
            end
        end
        exp_q[i].push_back(wire_order(d, lf));
        @(negedge clk);
    endtask

    task automatic idle(input int i);
        fifo_valid[i] = 1'b0;
    endtask

    task automatic wait_idle(input int i);
        int t = 0;
        while (busy[i] || exp_q[i].size() != 0) begin
            @(negedge clk);
            if (++t > 5000) begin
                chk($sformatf("idle_timeout%0d", i), 0, 1);
                return;
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic rand_run(input int i, input int n);
        for (int k = 0; k < n; k++) begin
            logic [DW:0] d;
            logic be, lf;
            d  = (DW+1)'($urandom);
            be = 1'($urandom_range(0, 1));
            lf = 1'($urandom_range(0, 1));
            send(i, d, be, lf);
            if ($urandom_range(0, 2) == 0) begin
                idle(i);
                repeat ($urandom_range(0, 20)) @(negedge clk);
            end
        end
        idle(i);
        wait_idle(i);
    endtask

    initial begin
        int rises, t;
        logic ps;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            fifo_valid[i] = 0; fifo_data[i] = '0; burst_en[i] = 0; lsb_first[i] = 0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_cs%0d", i), cs[i], 1);
            chk($sformatf("rst_sclk_sda_dc_wd%0d", i), {sclk[i], sda[i], dc[i], wd[i]}, 0);
            chk($sformatf("rst_busy%0d", i), busy[i], 0);
        end
        #1 rst_n = 1'b1;
        @(negedge clk);

        // Single word, D/C=1, payload 2C.
        send(0, 9'h12C, 1'b0, 1'b0); idle(0); wait_idle(0);
        // Burst pair with CS held low, then the same pair as two separate frames.
        send(0, 9'h02A, 1'b1, 1'b0); send(0, 9'h155, 1'b1, 1'b0); idle(0); wait_idle(0);
        send(0, 9'h02A, 1'b0, 1'b0); send(0, 9'h155, 1'b0, 1'b0); idle(0); wait_idle(0);
        // Bit order selection (collapses to MSB-first when the option is not built).
        send(0, 9'h0A1, 1'b0, 1'b1); idle(0); wait_idle(0);
        send(0, 9'h0A1, 1'b0, 1'b0); idle(0); wait_idle(0);
        // Divided clock instance.
        send(1, 9'h0FF, 1'b0, 1'b0); idle(1); wait_idle(1);
        send(1, 9'h1A5, 1'b1, 1'b0); send(1, 9'h03C, 1'b0, 1'b0); idle(1); wait_idle(1);

        // Asynchronous reset after the third rising SCLK edge of a word.
        send(0, 9'h13C, 1'b0, 1'b0); idle(0);
        rises = 0; t = 0; ps = sclk[0];
        while (rises < 3 && t < 500) begin
            @(negedge clk); t++;
            if (sclk[0] && !ps) rises++;
            ps = sclk[0];
        end
        chk("rst_wait_rises", rises, 3);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_cs", cs[0], 1);
        chk("midrst_sclk_sda", {sclk[0], sda[0]}, 0);
        chk("midrst_busy", busy[0], 0);
        exp_q[0].delete();
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        #1 chk("post_rst_ready", ready[0], 1);
        @(negedge clk);
        send(0, 9'h0A5, 1'b0, 1'b0); idle(0); wait_idle(0);

        fork
            rand_run(0, 60);
            rand_run(1, 25);
        join

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
